data_memory_pipelined: RTL and testbench

- Next-generation data memory for the CPU data path: synchronous-read RAM with a valid/ready request port, a configurable read-latency pipeline and an out-of-range flag.
- Debug probing moves from a mux onto an arbitrated, handshaked port.
- Sits between the load/store unit and the debug/probe controller.
- Replaces the combinational-read memory so it can map onto block RAM.

---
 rtl/data_memory_pipelined.sv | 135 +++++++++++++
 tb/tb_data_memory_pipelined.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/data_memory_pipelined.sv
// data_memory_pipelined: synchronous-read data RAM with a CPU valid/ready port, a debug read port and a READ_LATENCY response pipeline
// Ports: clk, reset (sync, active high)
//   CPU  : req_valid/req_ready/req_write/req_addr/req_wdata in, rsp_valid/rsp_rdata/rsp_oob out
//   Debug: debug_enable/debug_addr in, debug_grant/debug_rvalid/debug_rdata out
// Build option: DMEM_ZEROIZE_EN adds a CLEAR sweep writing zeros to every word after reset
module data_memory_pipelined #(
  parameter int D_ADDR_W       = 12,
  parameter int DATA_W         = 8,
  parameter int D_MEMORY_DEPTH = 1 << D_ADDR_W,
  parameter int READ_LATENCY   = 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_write,
  input  logic [D_ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0]   req_wdata,
  output logic                rsp_valid,
  output logic [DATA_W-1:0]   rsp_rdata,
  output logic                rsp_oob,
  input  logic                debug_enable,
  output logic                debug_grant,
  input  logic [D_ADDR_W-1:0] debug_addr,
  output logic                debug_rvalid,
  output logic [DATA_W-1:0]   debug_rdata
);
  localparam int IDX_W = D_MEMORY_DEPTH > 1 ? $clog2(D_MEMORY_DEPTH) : 1;
  localparam logic [D_ADDR_W:0] DEPTH_C = (D_ADDR_W+1)'(D_MEMORY_DEPTH);
  typedef enum logic [2:0] {ST_CPU, ST_DRAIN, ST_DEBUG, ST_DRAIN_DBG, ST_CLEAR} state_t;
  state_t r_state, w_state_nx;
  logic [DATA_W-1:0] r_mem [D_MEMORY_DEPTH];
  logic w_accept, w_wr, w_req_oob, w_iss_v, w_iss_g, w_iss_o, w_busy, w_pipe_busy;
  logic w_last_v, w_last_g, w_last_o;
  logic [D_ADDR_W-1:0] w_iss_addr;
  logic [DATA_W-1:0] w_iss_d, w_last_d;
  logic r_rsp_valid, r_rsp_oob, r_dbg_rvalid;
  logic [DATA_W-1:0] r_rsp_rdata, r_dbg_rdata;
  assign req_ready    = r_state == ST_CPU && !debug_enable;
  assign debug_grant  = r_state == ST_DEBUG;
  assign rsp_valid    = r_rsp_valid;
  assign rsp_oob      = r_rsp_oob;
  assign rsp_rdata    = r_rsp_rdata;
  assign debug_rvalid = r_dbg_rvalid;
  assign debug_rdata  = r_dbg_rdata;
  assign w_accept   = req_valid && req_ready;
  assign w_req_oob  = {1'b0, req_addr} >= DEPTH_C;
  assign w_wr       = w_accept && req_write && !w_req_oob && !reset;
  // the debug port owns the single read port for every granted cycle
  assign w_iss_g    = r_state == ST_DEBUG;
  assign w_iss_v    = w_iss_g || (w_accept && !req_write);
  assign w_iss_addr = w_iss_g ? debug_addr : req_addr;
  assign w_iss_o    = {1'b0, w_iss_addr} >= DEPTH_C;
  assign w_iss_d    = w_iss_o ? '0 : r_mem[w_iss_addr[IDX_W-1:0]];
`ifdef DMEM_ZEROIZE_EN
  localparam state_t RST_STATE = ST_CLEAR;
  logic [D_ADDR_W-1:0] r_clr;
  always_ff @(posedge clk) begin
    r_clr <= (reset || r_state != ST_CLEAR) ? '0 : r_clr + 1'b1;
  end
  always_ff @(posedge clk) begin
    if (r_state == ST_CLEAR && !reset) r_mem[r_clr[IDX_W-1:0]] <= '0;
    if (w_wr) r_mem[req_addr[IDX_W-1:0]] <= req_wdata;
  end
`else
  localparam state_t RST_STATE = ST_CPU;
  always_ff @(posedge clk) begin
    if (w_wr) r_mem[req_addr[IDX_W-1:0]] <= req_wdata;
  end
`endif
  // the output registers are the final latency stage; extra stages sit in front of them
  generate
    if (READ_LATENCY == 1) begin : g_direct
      assign w_last_v    = w_iss_v;
      assign w_last_g    = w_iss_g;
      assign w_last_o    = w_iss_o;
      assign w_last_d    = w_iss_d;
      assign w_pipe_busy = 1'b0;
    end else begin : g_pipe
      logic [READ_LATENCY-2:0] r_pv, r_pg, r_po;
      logic [DATA_W-1:0] r_pd [READ_LATENCY-1];
      always_ff @(posedge clk) begin
        for (int k = READ_LATENCY-2; k > 0; k--) begin
          r_pv[k] <= r_pv[k-1];
          r_pg[k] <= r_pg[k-1];
          r_po[k] <= r_po[k-1];
          r_pd[k] <= r_pd[k-1];
        end
        r_pv[0] <= w_iss_v;
        r_pg[0] <= w_iss_g;
        r_po[0] <= w_iss_o;
        r_pd[0] <= w_iss_d;
        if (reset) r_pv <= '0;
      end
      assign w_last_v    = r_pv[READ_LATENCY-2];
      assign w_last_g    = r_pg[READ_LATENCY-2];
      assign w_last_o    = r_po[READ_LATENCY-2];
      assign w_last_d    = r_pd[READ_LATENCY-2];
      assign w_pipe_busy = |r_pv;
    end
  endgenerate
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rsp_valid  <= 1'b0;
      r_rsp_oob    <= 1'b0;
      r_dbg_rvalid <= 1'b0;
      r_rsp_rdata  <= '0;
      r_dbg_rdata  <= '0;
    end else begin
      r_rsp_valid  <= w_last_v && !w_last_g;
      r_rsp_oob    <= w_last_v && !w_last_g && w_last_o;
      r_dbg_rvalid <= w_last_v && w_last_g;
      if (w_last_v && !w_last_g) r_rsp_rdata <= w_last_d;
      if (w_last_v && w_last_g) r_dbg_rdata <= w_last_d;
    end
  end
  // ownership only changes hands once every response, including the one on the outputs now, is gone
  assign w_busy = w_pipe_busy || r_rsp_valid || r_dbg_rvalid;
  always_comb begin
    w_state_nx = r_state;
    case (r_state)
      ST_CPU:       w_state_nx = debug_enable ? ST_DRAIN : ST_CPU;
      ST_DRAIN:     w_state_nx = !debug_enable ? ST_CPU : (w_busy ? ST_DRAIN : ST_DEBUG);
      ST_DEBUG:     w_state_nx = debug_enable ? ST_DEBUG : ST_DRAIN_DBG;
      ST_DRAIN_DBG: w_state_nx = w_busy ? ST_DRAIN_DBG : ST_CPU;
`ifdef DMEM_ZEROIZE_EN
      ST_CLEAR:     w_state_nx = r_clr == D_ADDR_W'(D_MEMORY_DEPTH-1) ? ST_CPU : ST_CLEAR;
`endif
      default:      w_state_nx = ST_CPU;
    endcase
  end
  always_ff @(posedge clk) begin
    r_state <= reset ? RST_STATE : w_state_nx;
  end
endmodule

// File: tb/tb_data_memory_pipelined.sv
// tb_data_memory_pipelined: directed self-checking bench for data_memory_pipelined
module tb_data_memory_pipelined;
  localparam int AW = 12, DW = 8, DEPTH = 3000, RL = 2;
  logic clk = 1'b0;
  logic reset = 1'b1, req_valid = 1'b0, req_write = 1'b0, debug_enable = 1'b0;
  logic [AW-1:0] req_addr = '0, debug_addr = '0;
  logic [DW-1:0] req_wdata = '0;
  logic req_ready, rsp_valid, rsp_oob, debug_grant, debug_rvalid;
  logic [DW-1:0] rsp_rdata, debug_rdata;
  int errors = 0, checks = 0;
  always #5 clk = ~clk;
  data_memory_pipelined #(.D_ADDR_W(AW), .DATA_W(DW), .D_MEMORY_DEPTH(DEPTH), .READ_LATENCY(RL)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_oob(rsp_oob),
    .debug_enable(debug_enable), .debug_grant(debug_grant), .debug_addr(debug_addr),
    .debug_rvalid(debug_rvalid), .debug_rdata(debug_rdata)
  );
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic drive(input logic v, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
    req_valid = v;
    req_write = w;
    req_addr  = a;
    req_wdata = d;
  endtask
  task automatic wait_ready(output int n);
    n = 0;
    while (!req_ready && n < DEPTH + 20) begin
      tick();
      n++;
    end
  endtask
  task automatic test_reset();
    int n;
    reset = 1'b1;
    debug_enable = 1'b0;
    drive(1'b0, 1'b0, 12'h000, 8'h00);
    tick();
    tick();
    checks++;
    if ({rsp_valid, rsp_oob, debug_grant, debug_rvalid} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_flags: got %b want 0000", {rsp_valid, rsp_oob, debug_grant, debug_rvalid});
    end
    checks++;
    if (rsp_rdata !== 8'h00 || debug_rdata !== 8'h00) begin
      errors++;
      $display("FAIL reset_data: got rsp=%h dbg=%h want 00/00", rsp_rdata, debug_rdata);
    end
    reset = 1'b0;
`ifdef DMEM_ZEROIZE_EN
    wait_ready(n);
    checks++;
    if (n != DEPTH) begin
      errors++;
      $display("FAIL clear_cycles: got %0d want %0d", n, DEPTH);
    end
`else
    n = 0;
    tick();
    checks++;
    if (req_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready: got %b want 1 (n=%0d)", req_ready, n);
    end
`endif
  endtask
`ifdef DMEM_ZEROIZE_EN
  task automatic test_zeroize();
    drive(1'b1, 1'b0, 12'h007, 8'h00);
    tick();
    drive(1'b0, 1'b0, 12'h000, 8'h00);
    tick();
    checks++;
    if (rsp_valid !== 1'b1 || rsp_rdata !== 8'h00) begin
      errors++;
      $display("FAIL zeroize_read: got v=%b d=%h want 1/00", rsp_valid, rsp_rdata);
    end
  endtask
`endif
  task automatic test_raw();
    drive(1'b1, 1'b1, 12'h010, 8'hA5);
    tick();
    drive(1'b1, 1'b0, 12'h010, 8'h00);
    tick();
    drive(1'b0, 1'b0, 12'h000, 8'h00);
    checks++;
    if (rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL raw_early: rsp_valid got %b want 0", rsp_valid);
    end
    tick();
    checks++;
    if (rsp_valid !== 1'b1) begin
      errors++;
      $display("FAIL raw_valid: got %b want 1", rsp_valid);
    end
    checks++;
    if (rsp_rdata !== 8'hA5 || rsp_oob !== 1'b0) begin
      errors++;
      $display("FAIL raw_data: got %h oob=%b want a5 oob=0", rsp_rdata, rsp_oob);
    end
    tick();
    checks++;
    if (rsp_valid !== 1'b0 || rsp_rdata !== 8'hA5) begin
      errors++;
      $display("FAIL raw_hold: got v=%b d=%h want 0/a5", rsp_valid, rsp_rdata);
    end
  endtask
  task automatic test_back_to_back();
    logic exp_v;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 1'b1, AW'(i), DW'((i + 1) * 17));
      tick();
    end
    for (int c = 0; c < 7; c++) begin
      if (c < 4) drive(1'b1, 1'b0, AW'(c), 8'h00);
      else drive(1'b0, 1'b0, 12'h000, 8'h00);
      tick();
      exp_v = c >= 1 && c <= 4;
      checks++;
      if (rsp_valid !== exp_v) begin
        errors++;
        $display("FAIL b2b_valid[%0d]: got %b want %b", c, rsp_valid, exp_v);
      end
      if (exp_v) begin
        checks++;
        if (rsp_rdata !== DW'(c * 17)) begin
          errors++;
          $display("FAIL b2b_data[%0d]: got %h want %h", c, rsp_rdata, DW'(c * 17));
        end
      end
    end
  endtask
  task automatic test_oob();
    drive(1'b1, 1'b1, 12'hBB8, 8'hFF);
    tick();
    drive(1'b1, 1'b1, 12'hBB7, 8'h5C);
    tick();
    drive(1'b1, 1'b0, 12'hBB8, 8'h00);
    tick();
    drive(1'b1, 1'b0, 12'hBB7, 8'h00);
    tick();
    checks++;
    if (rsp_valid !== 1'b1 || rsp_rdata !== 8'h00 || rsp_oob !== 1'b1) begin
      errors++;
      $display("FAIL oob_bb8: got v=%b d=%h oob=%b want 1/00/1", rsp_valid, rsp_rdata, rsp_oob);
    end
    drive(1'b1, 1'b0, 12'hFFF, 8'h00);
    tick();
    checks++;
    if (rsp_valid !== 1'b1 || rsp_rdata !== 8'h5C || rsp_oob !== 1'b0) begin
      errors++;
      $display("FAIL oob_bb7: got v=%b d=%h oob=%b want 1/5c/0", rsp_valid, rsp_rdata, rsp_oob);
    end
    drive(1'b0, 1'b0, 12'h000, 8'h00);
    tick();
    checks++;
    if (rsp_valid !== 1'b1 || rsp_rdata !== 8'h00 || rsp_oob !== 1'b1) begin
      errors++;
      $display("FAIL oob_fff: got v=%b d=%h oob=%b want 1/00/1", rsp_valid, rsp_rdata, rsp_oob);
    end
    tick();
    checks++;
    if (rsp_valid !== 1'b0 || rsp_oob !== 1'b0) begin
      errors++;
      $display("FAIL oob_idle: got v=%b oob=%b want 0/0", rsp_valid, rsp_oob);
    end
  endtask
  task automatic test_debug();
    int n, bad;
    drive(1'b1, 1'b0, 12'h000, 8'h00);
    tick();
    drive(1'b1, 1'b0, 12'h001, 8'h00);
    tick();
    checks++;
    if (rsp_valid !== 1'b1 || rsp_rdata !== 8'h11) begin
      errors++;
      $display("FAIL dbg_cpu0: got v=%b d=%h want 1/11", rsp_valid, rsp_rdata);
    end
    drive(1'b1, 1'b0, 12'h002, 8'h00);
    debug_enable = 1'b1;
    #1;
    checks++;
    if (req_ready !== 1'b0) begin
      errors++;
      $display("FAIL dbg_ready_drop: got %b want 0", req_ready);
    end
    tick();
    checks++;
    if (rsp_valid !== 1'b1 || rsp_rdata !== 8'h22 || debug_grant !== 1'b0) begin
      errors++;
      $display("FAIL dbg_cpu1: got v=%b d=%h grant=%b want 1/22/0", rsp_valid, rsp_rdata, debug_grant);
    end
    drive(1'b0, 1'b0, 12'h000, 8'h00);
    debug_addr = 12'h010;
    n = 0;
    bad = 0;
    while (!debug_grant && n < 20) begin
      tick();
      n++;
      if (rsp_valid || req_ready) bad++;
    end
    checks++;
    if (debug_grant !== 1'b1) begin
      errors++;
      $display("FAIL dbg_grant: got %b want 1 after %0d cycles", debug_grant, n);
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL dbg_drain: got %0d cycles with rsp_valid/req_ready want 0", bad);
    end
    tick();
    checks++;
    if (debug_rvalid !== 1'b0) begin
      errors++;
      $display("FAIL dbg_latency: rvalid got %b want 0", debug_rvalid);
    end
    debug_addr = 12'hBB8;
    tick();
    checks++;
    if (debug_rvalid !== 1'b1 || debug_rdata !== 8'hA5 || rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL dbg_read: got v=%b d=%h rsp_v=%b want 1/a5/0", debug_rvalid, debug_rdata, rsp_valid);
    end
    debug_addr = 12'h003;
    tick();
    checks++;
    if (debug_rvalid !== 1'b1 || debug_rdata !== 8'h00) begin
      errors++;
      $display("FAIL dbg_oob: got v=%b d=%h want 1/00", debug_rvalid, debug_rdata);
    end
    debug_enable = 1'b0;
    tick();
    checks++;
    if (debug_rvalid !== 1'b1 || debug_rdata !== 8'h44 || debug_grant !== 1'b0 || req_ready !== 1'b0) begin
      errors++;
      $display("FAIL dbg_release: got v=%b d=%h grant=%b ready=%b want 1/44/0/0", debug_rvalid, debug_rdata, debug_grant, req_ready);
    end
    n = 0;
    bad = 0;
    while (!req_ready && n < 20) begin
      tick();
      n++;
      if (rsp_valid || debug_grant) bad++;
    end
    checks++;
    if (req_ready !== 1'b1 || bad != 0) begin
      errors++;
      $display("FAIL dbg_back_to_cpu: got ready=%b bad=%0d want 1/0", req_ready, bad);
    end
    checks++;
    if (debug_rvalid !== 1'b0 || debug_rdata !== 8'h44) begin
      errors++;
      $display("FAIL dbg_hold: got v=%b d=%h want 0/44", debug_rvalid, debug_rdata);
    end
  endtask
  task automatic test_reset_inflight();
    int n;
    logic [DW-1:0] exp_d;
    drive(1'b1, 1'b0, 12'h010, 8'h00);
    tick();
    drive(1'b0, 1'b0, 12'h000, 8'h00);
    reset = 1'b1;
    tick();
    checks++;
    if (rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL rst_flight_a: rsp_valid got %b want 0", rsp_valid);
    end
    reset = 1'b0;
    tick();
    checks++;
    if (rsp_valid !== 1'b0 || rsp_rdata !== 8'h00) begin
      errors++;
      $display("FAIL rst_flight_b: got v=%b d=%h want 0/00", rsp_valid, rsp_rdata);
    end
`ifdef DMEM_ZEROIZE_EN
    wait_ready(n);
    exp_d = 8'h00;
`else
    n = 0;
    exp_d = 8'hA5;
`endif
    checks++;
    if (req_ready !== 1'b1) begin
      errors++;
      $display("FAIL rst_ready: got %b want 1 (waited %0d)", req_ready, n);
    end
    drive(1'b1, 1'b0, 12'h010, 8'h00);
    tick();
    drive(1'b0, 1'b0, 12'h000, 8'h00);
    tick();
    checks++;
    if (rsp_valid !== 1'b1 || rsp_rdata !== exp_d) begin
      errors++;
      $display("FAIL rst_keep: got v=%b d=%h want 1/%h", rsp_valid, rsp_rdata, exp_d);
    end
  endtask
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end
  initial begin
    test_reset();
`ifdef DMEM_ZEROIZE_EN
    test_zeroize();
`endif
    test_raw();
    test_back_to_back();
    test_oob();
    test_debug();
    test_reset_inflight();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
